// File: rtl/sramlike_bridge.sv
// CPU SRAM-style port to sram-like bus bridge with one outstanding transaction.
// Write strobes are mapped to the narrowest aligned bus size; odd patterns go full-width.
module sramlike_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned READ_ONLY = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    input  logic                cpu_hold,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                addr_ok,
    input  logic                data_ok
);
    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(NB);
    localparam logic [1:0]  FULL_SIZE = 2'(OFF_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              cap_c;
    logic              comp_c;
    logic              dec_wr;
    logic [1:0]        dec_size;
    logic [OFF_W-1:0]  dec_off;
    logic [DATA_W-1:0] rdata_q;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_addr[OFF_W-1:0];

    // Strobe decode: match single byte, aligned half, aligned word; else full width.
    always_comb begin
        dec_wr   = 1'b0;
        dec_size = FULL_SIZE;
        dec_off  = '0;
        if (READ_ONLY == 0 && cpu_wen != '0) begin
            dec_wr = 1'b1;
            for (int k = 0; k < NB; k++) begin
                if (cpu_wen == (NB'(1) << k)) begin
                    dec_size = 2'd0;
                    dec_off  = OFF_W'(k);
                end
            end
            for (int j = 0; j < NB; j += 2) begin
                if (cpu_wen == (NB'(2'b11) << j)) begin
                    dec_size = 2'd1;
                    dec_off  = OFF_W'(j);
                end
            end
            for (int j = 0; j < NB; j += 4) begin
                if (cpu_wen == (NB'(4'hF) << j)) begin
                    dec_size = 2'd2;
                    dec_off  = OFF_W'(j);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_c     = 1'b0;
        comp_c    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_en) begin
                    cap_c     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (addr_ok) begin
                    if (data_ok) begin
                        comp_c    = 1'b1;
                        state_nxt = cpu_hold ? DONE : IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_ok) begin
                    comp_c    = 1'b1;
                    state_nxt = cpu_hold ? DONE : IDLE;
                end
            end
            DONE: begin
                if (!cpu_hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request payload is frozen at capture so it stays stable while req is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr      <= 1'b0;
            size    <= 2'd0;
            addr    <= '0;
            wdata   <= '0;
            rdata_q <= '0;
        end else begin
            if (cap_c) begin
                wr    <= dec_wr;
                size  <= dec_size;
                addr  <= {cpu_addr[ADDR_W-1:OFF_W], dec_off};
                wdata <= cpu_wdata;
            end
            if (comp_c) begin
                rdata_q <= rdata;
            end
        end
    end

    assign req       = (state == REQ);
    assign cpu_rdata = comp_c ? rdata : rdata_q;
    assign cpu_stall = rst & cpu_en & ~(comp_c | (state == DONE));

endmodule

// File: tb/tb_sramlike_bridge.sv
// Scoreboard bench for sramlike_bridge: 32-bit, 32-bit read-only and 64-bit instances.
module tb_sramlike_bridge;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] wdata;
    } exp_req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_en, a_hold, a_req, a_wr, a_stall, a_aok, a_dok;
    logic [3:0]  a_wen;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata_cpu, a_saddr, a_swdata, a_srdata;

    logic        b_en, b_hold, b_req, b_wr, b_stall, b_aok, b_dok;
    logic [3:0]  b_wen;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata_cpu, b_saddr, b_swdata, b_srdata;

    logic        c_en, c_hold, c_req, c_wr, c_stall, c_aok, c_dok;
    logic [7:0]  c_wen;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_saddr;
    logic [63:0] c_wdata, c_rdata_cpu, c_swdata, c_srdata;

    sramlike_bridge #(.ADDR_W(32), .DATA_W(32), .READ_ONLY(0)) u_a (
        .clk(clk), .rst(rst), .cpu_en(a_en), .cpu_wen(a_wen), .cpu_addr(a_addr),
        .cpu_wdata(a_wdata), .cpu_rdata(a_rdata_cpu), .cpu_stall(a_stall), .cpu_hold(a_hold),
        .req(a_req), .wr(a_wr), .size(a_size), .addr(a_saddr), .wdata(a_swdata),
        .rdata(a_srdata), .addr_ok(a_aok), .data_ok(a_dok)
    );

    sramlike_bridge #(.ADDR_W(32), .DATA_W(32), .READ_ONLY(1)) u_b (
        .clk(clk), .rst(rst), .cpu_en(b_en), .cpu_wen(b_wen), .cpu_addr(b_addr),
        .cpu_wdata(b_wdata), .cpu_rdata(b_rdata_cpu), .cpu_stall(b_stall), .cpu_hold(b_hold),
        .req(b_req), .wr(b_wr), .size(b_size), .addr(b_saddr), .wdata(b_swdata),
        .rdata(b_srdata), .addr_ok(b_aok), .data_ok(b_dok)
    );

    sramlike_bridge #(.ADDR_W(32), .DATA_W(64), .READ_ONLY(0)) u_c (
        .clk(clk), .rst(rst), .cpu_en(c_en), .cpu_wen(c_wen), .cpu_addr(c_addr),
        .cpu_wdata(c_wdata), .cpu_rdata(c_rdata_cpu), .cpu_stall(c_stall), .cpu_hold(c_hold),
        .req(c_req), .wr(c_wr), .size(c_size), .addr(c_saddr), .wdata(c_swdata),
        .rdata(c_srdata), .addr_ok(c_aok), .data_ok(c_dok)
    );

    int n_chk  = 0;
    int n_fail = 0;

    exp_req_t    q_a[$];
    exp_req_t    q_b[$];
    exp_req_t    q_c[$];
    logic [31:0] q_rd[$];
    exp_req_t    ea, eb, ec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_req(input string tag, input exp_req_t e, input logic wr,
                           input logic [1:0] sz, input logic [31:0] ad, input logic [63:0] wd);
        chk({tag, "_wr"},    64'(wr), 64'(e.wr));
        chk({tag, "_size"},  64'(sz), 64'(e.size));
        chk({tag, "_addr"},  64'(ad), 64'(e.addr));
        chk({tag, "_wdata"}, wd,      e.wdata);
    endtask

    function automatic exp_req_t mk(input logic wr, input logic [1:0] sz,
                                    input logic [31:0] ad, input logic [63:0] wd);
        return {wr, sz, ad, wd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop an expectation at every bus handshake and every CPU-consumed result.
    always @(negedge clk) begin
        if (rst) begin
            if (a_req && a_aok) begin
                chk("a_req_expected", 64'(q_a.size() != 0), 64'd1);
                if (q_a.size() != 0) begin
                    ea = q_a.pop_front();
                    cmp_req("a", ea, a_wr, a_size, a_saddr, 64'(a_swdata));
                end
            end
            if (a_en && !a_stall && !a_hold) begin
                chk("a_rd_expected", 64'(q_rd.size() != 0), 64'd1);
                if (q_rd.size() != 0) chk("a_cpu_rdata", 64'(a_rdata_cpu), 64'(q_rd.pop_front()));
            end
            if (b_req && b_aok) begin
                chk("b_req_expected", 64'(q_b.size() != 0), 64'd1);
                if (q_b.size() != 0) begin
                    eb = q_b.pop_front();
                    cmp_req("b", eb, b_wr, b_size, b_saddr, 64'(b_swdata));
                end
            end
            if (c_req && c_aok) begin
                chk("c_req_expected", 64'(q_c.size() != 0), 64'd1);
                if (q_c.size() != 0) begin
                    ec = q_c.pop_front();
                    cmp_req("c", ec, c_wr, c_size, c_saddr, c_swdata);
                end
            end
        end
    end

    task automatic c_txn(input logic [7:0] wen, input logic [31:0] ad, input logic [63:0] wd,
                         input logic ewr, input logic [1:0] esz, input logic [31:0] ead);
        q_c.push_back(mk(ewr, esz, ead, wd));
        c_en = 1'b1; c_wen = wen; c_addr = ad; c_wdata = wd; c_aok = 1'b1; c_dok = 1'b1;
        step();
        step();
        c_en = 1'b0;
        step();
    endtask

    initial begin
        a_en = 1'b1; a_hold = 1'b0; a_wen = '0; a_addr = '0; a_wdata = '0;
        a_aok = 1'b0; a_dok = 1'b0; a_srdata = '0;
        b_en = 1'b0; b_hold = 1'b0; b_wen = '0; b_addr = '0; b_wdata = '0;
        b_aok = 1'b0; b_dok = 1'b0; b_srdata = '0;
        c_en = 1'b0; c_hold = 1'b0; c_wen = '0; c_addr = '0; c_wdata = '0;
        c_aok = 1'b0; c_dok = 1'b0; c_srdata = '0;

        // Reset with cpu_en high: everything observable must be zero.
        step();
        step();
        @(negedge clk);
        chk("rst_stall", 64'(a_stall), 64'd0);
        chk("rst_req",   64'(a_req),   64'd0);
        chk("rst_wr",    64'(a_wr),    64'd0);
        chk("rst_size",  64'(a_size),  64'd0);
        chk("rst_addr",  64'(a_saddr), 64'd0);
        chk("rst_wdata", 64'(a_swdata), 64'd0);
        chk("rst_rdata", 64'(a_rdata_cpu), 64'd0);
        step();
        a_en = 1'b0;
        rst  = 1'b1;

        // Minimum-latency read, unaligned CPU address.
        step();
        a_en = 1'b1; a_wen = 4'h0; a_addr = 32'h43; a_wdata = 32'h0;
        a_aok = 1'b1; a_dok = 1'b1; a_srdata = 32'h12345678;
        q_a.push_back(mk(1'b0, 2'd2, 32'h40, 64'h0));
        q_rd.push_back(32'h12345678);
        @(negedge clk);
        chk("s1_stall_cycle1", 64'(a_stall), 64'd1);
        chk("s1_req_cycle1",   64'(a_req),   64'd0);
        step();
        @(negedge clk);
        chk("s1_req_cycle2",   64'(a_req),   64'd1);
        chk("s1_stall_cycle2", 64'(a_stall), 64'd0);
        step();
        a_en = 1'b0; a_srdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("s1_req_cycle3",         64'(a_req),       64'd0);
        chk("s1_rdata_ignored_idle", 64'(a_rdata_cpu), 64'h12345678);

        // Upper-halfword write with addr_ok held off for three cycles.
        step();
        a_aok = 1'b0; a_dok = 1'b0; a_srdata = 32'h0;
        a_en = 1'b1; a_wen = 4'b1100; a_addr = 32'h100; a_wdata = 32'hAABB0000;
        q_a.push_back(mk(1'b1, 2'd1, 32'h102, 64'hAABB0000));
        q_rd.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("s2_req_held",    64'(a_req),   64'd1);
            chk("s2_addr_stable", 64'(a_saddr), 64'h102);
            chk("s2_stall_held",  64'(a_stall), 64'd1);
        end
        step();
        a_aok = 1'b1;
        step();
        a_aok = 1'b0; a_dok = 1'b1;
        @(negedge clk);
        chk("s2_stall_done", 64'(a_stall), 64'd0);
        step();
        a_en = 1'b0; a_dok = 1'b0;

        // Read completing under cpu_hold; rdata valid for one cycle only.
        step();
        a_en = 1'b1; a_wen = 4'h0; a_addr = 32'h200; a_wdata = 32'h0;
        a_aok = 1'b1; a_dok = 1'b1; a_srdata = 32'hCAFEF00D;
        q_a.push_back(mk(1'b0, 2'd2, 32'h200, 64'h0));
        q_rd.push_back(32'hCAFEF00D);
        step();
        a_hold = 1'b1;
        @(negedge clk);
        chk("s3_stall_complete", 64'(a_stall),     64'd0);
        chk("s3_rdata_comb",     64'(a_rdata_cpu), 64'hCAFEF00D);
        step();
        a_aok = 1'b0; a_dok = 1'b0; a_srdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_stall_hold", 64'(a_stall),     64'd0);
            chk("s3_rdata_hold", 64'(a_rdata_cpu), 64'hCAFEF00D);
            chk("s3_req_hold",   64'(a_req),       64'd0);
            step();
        end
        a_hold = 1'b0;
        step();
        a_en = 1'b0;
        @(negedge clk);
        chk("s3_req_after_hold", 64'(a_req), 64'd0);

        // Reset while waiting for data; a late data_ok must be ignored.
        step();
        a_en = 1'b1; a_addr = 32'h300; a_aok = 1'b0; a_dok = 1'b0;
        q_a.push_back(mk(1'b0, 2'd2, 32'h300, 64'h0));
        step();
        a_aok = 1'b1;
        step();
        a_aok = 1'b0;
        @(negedge clk);
        chk("s6_stall_wait", 64'(a_stall), 64'd1);
        chk("s6_req_wait",   64'(a_req),   64'd0);
        step();
        rst = 1'b0; a_en = 1'b0;
        step();
        rst = 1'b1; a_dok = 1'b1; a_srdata = 32'h55555555;
        @(negedge clk);
        chk("s6_rdata_zero", 64'(a_rdata_cpu), 64'd0);
        chk("s6_req_idle",   64'(a_req),       64'd0);
        step();
        a_dok = 1'b0;
        @(negedge clk);
        chk("s6_rdata_zero2", 64'(a_rdata_cpu), 64'd0);
        chk("s6_req_idle2",   64'(a_req),       64'd0);

        // Read-only channel ignores write strobes.
        step();
        b_en = 1'b1; b_wen = 4'hF; b_addr = 32'h406; b_wdata = 32'h12345678;
        b_aok = 1'b1; b_dok = 1'b1;
        q_b.push_back(mk(1'b0, 2'd2, 32'h404, 64'h12345678));
        step();
        step();
        b_en = 1'b0;
        step();

        // 64-bit strobe decode table.
        c_txn(8'hF0, 32'h08, 64'h0123456789ABCDEF, 1'b1, 2'd2, 32'h0C);
        c_txn(8'h01, 32'h10, 64'h0123456789ABCDEF, 1'b1, 2'd0, 32'h10);
        c_txn(8'h08, 32'h10, 64'h0123456789ABCDEF, 1'b1, 2'd0, 32'h13);
        c_txn(8'h30, 32'h20, 64'h0123456789ABCDEF, 1'b1, 2'd1, 32'h24);
        c_txn(8'hC0, 32'h20, 64'h0123456789ABCDEF, 1'b1, 2'd1, 32'h26);
        c_txn(8'h0F, 32'h28, 64'h0123456789ABCDEF, 1'b1, 2'd2, 32'h28);
        c_txn(8'hFF, 32'h2D, 64'h0123456789ABCDEF, 1'b1, 2'd3, 32'h28);
        c_txn(8'h06, 32'h30, 64'h0123456789ABCDEF, 1'b1, 2'd3, 32'h30);
        c_txn(8'h00, 32'h3F, 64'h0123456789ABCDEF, 1'b0, 2'd3, 32'h38);

        step();
        step();
        chk("a_req_leftover", 64'(q_a.size()),  64'd0);
        chk("a_rd_leftover",  64'(q_rd.size()), 64'd0);
        chk("b_req_leftover", 64'(q_b.size()),  64'd0);
        chk("c_req_leftover", 64'(q_c.size()),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sramlike_bridge.md
SRAMLIKE_BRIDGE -- requirements
Module: sramlike_bridge

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  ADDR_W  32  address width
  DATA_W  32  data width; legal values 32 or 64
  READ_ONLY  0  1 = fetch channel: writes never issued, cpu_wen ignored
REQ-002 The block SHALL have one clock; reset is synchronous and active-low. Ports, one per line: name  direction  width  meaning.
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  synchronous active-low reset
  cpu_en  in  1  CPU SRAM-side access enable
  cpu_wen  in  DATA_W/8  byte write strobes; all-zero = read
  cpu_addr  in  ADDR_W  byte address
  cpu_wdata  in  DATA_W  write data
  cpu_rdata  out  DATA_W  read data to CPU
  cpu_stall  out  1  freeze CPU pipeline stage
  cpu_hold  in  1  CPU frozen by another source (e.g. divider); must not consume data
  req  out  1  sram-like request valid
  wr  out  1  1 = write
  size  out  2  0 byte, 1 half, 2 word, 3 dword
  addr  out  ADDR_W  sram-like address
  wdata  out  DATA_W  sram-like write data
  rdata  in  DATA_W  sram-like read data
  addr_ok  in  1  request accepted
  data_ok  in  1  data returned / write done

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-004 IDLE with cpu_en=1 SHALL register cpu_addr, cpu_wen, cpu_wdata and go to REQ next cycle; IDLE with cpu_en=0 SHALL stay IDLE.
REQ-005 req SHALL be 1 exactly when state is REQ; addr, wr, size, wdata SHALL come from the registered request and stay stable while req=1.
REQ-006 REQ with addr_ok=1 and data_ok=0 SHALL go to WAIT; REQ with addr_ok=0 SHALL stay in REQ.
REQ-007 Completion SHALL occur on data_ok=1 in WAIT, or on addr_ok=1 and data_ok=1 together in REQ.
REQ-008 On completion, cpu_rdata SHALL equal rdata combinationally in the same cycle and SHALL be captured into a register; the next state SHALL be DONE if cpu_hold=1, else IDLE.
REQ-009 In DONE, cpu_rdata SHALL come from the captured register; DONE SHALL go to IDLE on the first cycle with cpu_hold=0.
REQ-010 cpu_stall SHALL be cpu_en AND NOT (completion this cycle OR state==DONE).
REQ-011 Minimum latency SHALL be 2 cycles from cpu_en rising (IDLE) to cpu_stall=0, with addr_ok and data_ok both 1 in the first REQ cycle.
REQ-012 wr SHALL be 1 iff the registered wen is non-zero and READ_ONLY=0.
REQ-013 Reads SHALL use size = log2(DATA_W/8) with addr = registered address with its low log2(DATA_W/8) bits cleared.
REQ-014 Writes SHALL derive size and offset from the contiguous aligned strobe group:
  - single byte k: size 0, addr low bits = k
  - aligned halfword at byte 2j: size 1, low bits = 2j
  - aligned word at byte 4j: size 2, low bits = 4j
  - full 64-bit mask: size 3
REQ-015 Any other non-zero strobe pattern SHALL be issued as a full-width write at the aligned address with wdata unchanged.
REQ-016 wdata SHALL be the registered cpu_wdata unshifted.
REQ-017 data_ok received in IDLE or DONE SHALL be ignored and SHALL NOT change cpu_rdata.
REQ-018 At most one transaction SHALL be outstanding; no new req SHALL be issued before the previous completion.

Reset
REQ-019 While rst=0 at a rising edge, the state SHALL become IDLE, and req, wr, size, addr, wdata, the captured rdata register and cpu_stall SHALL all be 0.
REQ-020 Reset asserted in REQ or WAIT SHALL abandon the transaction; a late data_ok after reset SHALL be ignored per REQ-017.

Verification
REQ-021 The bench SHALL cover these directed scenarios.
  - Read, addr_ok and data_ok both 1 in the first REQ cycle, rdata=0x12345678 -> req high 1 cycle, cpu_stall low at cycle 2, cpu_rdata=0x12345678.
  - Write cpu_wen=4'b1100, cpu_addr=0x100 -> wr=1, size=1, addr=0x102; addr_ok delayed 3 cycles keeps req high with addr stable.
  - Read completes with cpu_hold=1 for 4 cycles, rdata=0xCAFEF00D for one cycle only -> cpu_rdata holds 0xCAFEF00D, cpu_stall=0 throughout hold, IDLE after hold drops.
  - READ_ONLY=1, cpu_wen=4'hF -> wr=0, size=2.
  - DATA_W=64, wen=8'hF0, addr=0x8 -> size=2, addr=0xC.
  - rst=0 while in WAIT, then data_ok=1 after release -> cpu_rdata remains 0, state IDLE, no req.
